// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants, FSM encoding and PRESENT-80 reference vectors
package present_pkg;

  localparam int BLK_W = 64;
  localparam int KEY_W = 80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } state_e;

  // Published known-answer ciphertexts, named KAT_K<key>_P<plaintext> (0 = all-zero, 1 = all-one)
  localparam logic [BLK_W-1:0] KAT_K0_P0 = 64'h5579c1387b228445;
  localparam logic [BLK_W-1:0] KAT_K0_P1 = 64'ha112ffc72f68417b;
  localparam logic [BLK_W-1:0] KAT_K1_P0 = 64'he72c46c0f5945049;
  localparam logic [BLK_W-1:0] KAT_K1_P1 = 64'h3333dcd3213210d2;

endpackage

// File: rtl/present_rr_arb2.sv
// rtl/present_rr_arb2.sv - two-input round-robin grant; on a tie the requester other than last wins
module present_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = valid_i[0] & (~valid_i[1] | last_i);
  assign gnt_o[1] = valid_i[1] & (~valid_i[0] | ~last_i);

endmodule

// File: rtl/present_enc_sched.sv
// rtl/present_enc_sched.sv - shares one PRESENT-80 core between two requesters with timeout
module present_enc_sched
  import present_pkg::*;
#(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [BLK_W-1:0] req0_idat,
  input  logic [KEY_W-1:0] req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [BLK_W-1:0] req1_idat,
  input  logic [KEY_W-1:0] req1_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [BLK_W-1:0] rsp_odat,
  output logic             core_load,
  output logic [BLK_W-1:0] core_idat,
  output logic [KEY_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_odat,
  input  logic             core_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               core_load_q, core_load_d;
  logic [BLK_W-1:0]   core_idat_q, core_idat_d;
  logic [KEY_W-1:0]   core_key_q, core_key_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic               rsp_err_q, rsp_err_d;
  logic [BLK_W-1:0]   rsp_odat_q, rsp_odat_d;
  logic [1:0]         gnt;
  logic               idle;

  present_rr_arb2 u_arb (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_q),
    .gnt_o   (gnt)
  );

  assign idle       = (state_q == IDLE);
  assign req0_ready = idle & gnt[0];
  assign req1_ready = idle & gnt[1];

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_odat   = rsp_odat_q;
  assign core_load  = core_load_q;
  assign core_idat  = core_idat_q;
  assign core_key   = core_key_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      core_load_q <= 1'b0;
      core_idat_q <= '0;
      core_key_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_odat_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      core_load_q <= core_load_d;
      core_idat_q <= core_idat_d;
      core_key_q  <= core_key_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_odat_q  <= rsp_odat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    core_load_d = 1'b0;
    core_idat_d = core_idat_q;
    core_key_d  = core_key_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_odat_d  = rsp_odat_q;
    case (state_q)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          core_idat_d = req1_ready ? req1_idat : req0_idat;
          core_key_d  = req1_ready ? req1_key : req0_key;
          rsp_id_d    = req1_ready;
          last_d      = req1_ready;
          core_load_d = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // done at cnt==0 may still be the previous block's level, so it is not trusted
        if (core_done && (cnt_q != '0)) begin
          rsp_odat_d  = core_odat;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_TO) begin
          rsp_odat_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_present_enc_sched.sv
// tb/tb_present_enc_sched.sv - scoreboard bench for present_enc_sched with a cycle-level PRESENT-80 core model
module tb_present_enc_sched;
  import present_pkg::*;

  localparam int TIMEOUT = 48;
  localparam logic [63:0] STUB_ODAT = 64'hdeadbeef01234567;

  typedef struct {
    logic        id;
    logic        err;
    logic [63:0] odat;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_idat, req1_idat;
  logic [79:0] req0_key, req1_key;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [63:0] rsp_odat;
  logic        core_load;
  logic [63:0] core_idat, core_odat;
  logic [79:0] core_key;
  logic        core_done;
  logic [1:0]  stub_mode;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic gq[$];
  bit   in_flight = 0;
  int   loads_blk = 0;
  int   load_cyc = 0;
  int   rsp_cyc = 0;
  bit   prev_valid = 0;
  bit   prev_hs = 0;
  logic [65:0] prev_fields = '0;
  int   viol_both = 0, viol_idle = 0, viol_stable = 0, viol_bp = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  present_enc_sched #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_idat  (req0_idat),
    .req0_key   (req0_key),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_idat  (req1_idat),
    .req1_key   (req1_key),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .rsp_odat   (rsp_odat),
    .core_load  (core_load),
    .core_idat  (core_idat),
    .core_key   (core_key),
    .core_odat  (core_odat),
    .core_done  (core_done)
  );

  // Iterative PRESENT-80 core: one round per clock after load, done is a level, no reset
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748fe3da09b65c;
    return tbl[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] round_f(input logic [63:0] s, input logic [79:0] k);
    logic [63:0] x, y;
    x = s ^ k[79:16];
    for (int n = 0; n < 16; n++) x[6'(4*n) +: 4] = sbox4(x[6'(4*n) +: 4]);
    y = '0;
    for (int i = 0; i < 63; i++) y[6'((i*16) % 63)] = x[6'(i)];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] key_upd(input logic [79:0] k, input int r);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox4(t[79:76]);
    t[19:15] = t[19:15] ^ 5'(r);
    return t;
  endfunction

  logic [63:0] cm_state;
  logic [79:0] cm_key;
  int          cm_rnd;
  bit          cm_run, cm_done;

  always @(posedge clk) begin
    if (core_load) begin
      cm_state <= core_idat;
      cm_key   <= core_key;
      cm_rnd   <= 1;
      cm_run   <= 1'b1;
      cm_done  <= 1'b0;
    end else if (cm_run) begin
      cm_state <= round_f(cm_state, cm_key);
      cm_key   <= key_upd(cm_key, cm_rnd);
      cm_rnd   <= cm_rnd + 1;
      if (cm_rnd == 31) begin
        cm_run  <= 1'b0;
        cm_done <= 1'b1;
      end
    end
  end

  assign core_odat = (stub_mode == 2'd0) ? (cm_state ^ cm_key[79:16]) : STUB_ODAT;
  assign core_done = (stub_mode == 2'd0) ? cm_done : (stub_mode == 2'd2);

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] outs();
    return 256'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_odat,
                 core_load, core_idat, core_key});
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (req0_ready && req1_ready) viol_both++;
      if ((req0_ready || req1_ready) && in_flight) viol_idle++;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        in_flight = 1;
        loads_blk = 0;
      end
      if (core_load) begin
        loads_blk++;
        load_cyc = cyc;
      end
      if (rsp_valid && core_load) viol_bp++;
      if (rsp_valid && prev_valid && !prev_hs && ({rsp_id, rsp_err, rsp_odat} !== prev_fields))
        viol_stable++;
      if (rsp_valid && !prev_valid) rsp_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got id=%0d odat=%0h, required no response", rsp_id, rsp_odat);
        end else begin
          e = exp_q.pop_front();
          check("rsp", 256'({rsp_id, rsp_err, rsp_odat}), 256'({e.id, e.err, e.odat}));
          check("one_load", 256'(loads_blk), 256'd1);
          if (e.lat >= 0) check("latency", 256'(rsp_cyc - load_cyc), 256'(e.lat));
        end
        in_flight = 0;
      end
      prev_valid  = rsp_valid;
      prev_hs     = rsp_valid && rsp_ready;
      prev_fields = {rsp_id, rsp_err, rsp_odat};
    end
  end

  task automatic send(input logic id, input logic [63:0] d, input logic [79:0] k, input bit keep,
                      input bit exp_en, input logic exp_err, input logic [63:0] exp_odat,
                      input int exp_lat);
    exp_t e;
    bit   got;
    got = 0;
    if (id) begin
      req1_valid = 1'b1; req1_idat = d; req1_key = k;
    end else begin
      req0_valid = 1'b1; req0_idat = d; req0_key = k;
    end
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_req%0d: ready not seen in 200 cycles, required a grant", id);
    end else begin
      gq.push_back(id);
      if (exp_en) begin
        e.id = id; e.err = exp_err; e.odat = exp_odat; e.lat = exp_lat;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (!keep) begin
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !in_flight;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: %0d responses outstanding after 500 cycles, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200us");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] g;
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_idat = '0; req0_key = '0;
    req1_valid = 1'b0; req1_idat = '0; req1_key = '0;
    rsp_ready = 1'b1;
    stub_mode = 2'd0;
    #2 check("reset_state", outs(), '0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    send(1'b0, '0, '0, 0, 1, 1'b0, KAT_K0_P0, -1);
    wait_idle();
    send(1'b1, '0, '1, 0, 1, 1'b0, KAT_K1_P0, -1);
    wait_idle();
    send(1'b1, '1, '1, 0, 1, 1'b0, KAT_K1_P1, -1);
    wait_idle();

    gq.delete();
    fork
      begin
        send(1'b0, '0, '0, 1, 1, 1'b0, KAT_K0_P0, -1);
        send(1'b0, '1, '0, 0, 1, 1'b0, KAT_K0_P1, -1);
      end
      begin
        send(1'b1, '0, '1, 1, 1, 1'b0, KAT_K1_P0, -1);
        send(1'b1, '1, '1, 0, 1, 1'b0, KAT_K1_P1, -1);
      end
    join
    wait_idle();
    g = '0;
    foreach (gq[i]) g = {g[2:0], gq[i]};
    check("grant_cnt", 256'(gq.size()), 256'd4);
    check("grant_order", 256'(g), 256'(4'b0101));

    rsp_ready = 1'b0;
    fork
      send(1'b0, '0, '1, 0, 1, 1'b0, KAT_K1_P0, -1);
      send(1'b1, '1, '0, 0, 1, 1'b0, KAT_K0_P1, -1);
      begin : bp
        bit seen;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
          @(negedge clk);
          seen = rsp_valid;
        end
        if (!seen) begin
          n_vec++;
          n_err++;
          $display("FAIL bp_rsp: rsp_valid not seen in 200 cycles, required a response");
        end
        repeat (20) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    wait_idle();

    stub_mode = 2'd1;
    send(1'b0, '0, '0, 0, 1, 1'b1, '0, TIMEOUT + 2);
    wait_idle();
    stub_mode = 2'd2;
    send(1'b1, '1, '1, 0, 1, 1'b0, STUB_ODAT, 3);
    wait_idle();
    stub_mode = 2'd0;

    send(1'b0, '1, '1, 0, 0, 1'b0, '0, -1);
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check("reset_async", outs(), '0);
    exp_q.delete();
    in_flight = 0; prev_valid = 0; prev_hs = 0; loads_blk = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    gq.delete();
    fork
      send(1'b0, '0, '1, 0, 1, 1'b0, KAT_K1_P0, -1);
      send(1'b1, '1, '0, 0, 1, 1'b0, KAT_K0_P1, -1);
    join
    wait_idle();
    g = '0;
    foreach (gq[i]) g = {g[2:0], gq[i]};
    check("post_reset_grants", 256'(gq.size()), 256'd2);
    check("post_reset_order", 256'(g), 256'(4'b0001));

    check("ready_both", 256'(viol_both), '0);
    check("ready_outside_idle", 256'(viol_idle), '0);
    check("rsp_stable", 256'(viol_stable), '0);
    check("load_during_rsp", 256'(viol_bp), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
